// File: rtl/random_dwell_scheduler.sv
// Two-state output sequencer whose dwell in each state is drawn from a
// programmable [min,max] range using a 16-bit Galois LFSR.
module random_dwell_scheduler #(
  parameter int          CNT_W      = 16,
  parameter int          DEF_MIN0   = 10,
  parameter int          DEF_MAX0   = 20,
  parameter int          DEF_MIN1   = 30,
  parameter int          DEF_MAX1   = 40,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter bit          INIT_STATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             a_rst_n_i,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CNT_W-1:0] cfg_min0_i,
  input  logic [CNT_W-1:0] cfg_max0_i,
  input  logic [CNT_W-1:0] cfg_min1_i,
  input  logic [CNT_W-1:0] cfg_max1_i,
  output logic             cfg_err_o,
  input  logic             seed_valid_i,
  input  logic [15:0]      seed_i,
  output logic             state_o,
  output logic             toggle_o,
  output logic             busy_o,
  output logic [15:0]      period_cnt_o
);

  typedef enum logic {IDLE, RUN} fsm_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          PROD_W    = 16 + CNT_W + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  fsm_t             fsm_reg, fsm_next;
  logic             state_reg, state_next;
  logic             toggle_reg, toggle_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      lfsr_reg, lfsr_next;
  logic [15:0]      period_reg, period_next;
  logic             cfg_err_reg;

  logic [CNT_W-1:0] cfg_min_in [2];
  logic [CNT_W-1:0] cfg_max_in [2];
  logic [CNT_W-1:0] min_q [2];
  logic [CNT_W-1:0] max_q [2];
  logic [1:0]       bound_ok;
  logic             cfg_fire, cfg_accept;

  assign cfg_min_in[0] = cfg_min0_i;
  assign cfg_max_in[0] = cfg_max0_i;
  assign cfg_min_in[1] = cfg_min1_i;
  assign cfg_max_in[1] = cfg_max1_i;

  assign cfg_fire   = cfg_valid_i & cfg_ready_o;
  assign cfg_accept = cfg_fire & (&bound_ok);

  // One bound pair per output state; a config is taken only if both pairs are sane.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bound
    logic [CNT_W-1:0] min_reg, max_reg;

    assign bound_ok[gi] = (cfg_min_in[gi] != '0) && (cfg_min_in[gi] <= cfg_max_in[gi]);

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
        min_reg <= CNT_W'(gi == 0 ? DEF_MIN0 : DEF_MIN1);
        max_reg <= CNT_W'(gi == 0 ? DEF_MAX0 : DEF_MAX1);
      end else if (cfg_accept) begin
        min_reg <= cfg_min_in[gi];
        max_reg <= cfg_max_in[gi];
      end
    end

    assign min_q[gi] = min_reg;
    assign max_q[gi] = max_reg;
  end

  // A seed presented in IDLE takes effect in the same cycle as a start draw.
  logic [15:0]       seed_val, lfsr_cur;
  logic              draw_state;
  logic [CNT_W-1:0]  draw_min, draw_max, draw_off, dwell, dwell_load;
  logic [CNT_W:0]    span;
  logic [PROD_W-1:0] prod;

  assign seed_val   = (seed_i == 16'h0000) ? LFSR_SEED : seed_i;
  assign lfsr_cur   = (fsm_reg == IDLE && seed_valid_i) ? seed_val : lfsr_reg;
  assign draw_state = (fsm_reg == IDLE) ? INIT_STATE : ~state_reg;
  assign draw_min   = min_q[draw_state];
  assign draw_max   = max_q[draw_state];
  assign span       = {1'b0, draw_max} - {1'b0, draw_min} + (CNT_W+1)'(1);
  assign prod       = PROD_W'(lfsr_cur) * PROD_W'(span);
  assign draw_off   = CNT_W'(prod >> 16);
  assign dwell      = draw_min + draw_off;
  assign dwell_load = dwell - CNT_W'(1);

  always_comb begin
    fsm_next    = fsm_reg;
    state_next  = state_reg;
    toggle_next = 1'b0;
    cnt_next    = cnt_reg;
    lfsr_next   = lfsr_reg;
    period_next = period_reg;
    case (fsm_reg)
      IDLE: begin
        if (seed_valid_i) lfsr_next = seed_val;
        if (en_i) begin
          fsm_next  = RUN;
          cnt_next  = dwell_load;
          lfsr_next = lfsr_step(lfsr_cur);
        end
      end
      RUN: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          if (state_reg) period_next = period_reg + 16'd1;
          if (en_i) begin
            state_next  = ~state_reg;
            toggle_next = 1'b1;
            cnt_next    = dwell_load;
            lfsr_next   = lfsr_step(lfsr_cur);
          end else begin
            fsm_next    = IDLE;
            state_next  = INIT_STATE;
            toggle_next = (state_reg != INIT_STATE);
          end
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      fsm_reg     <= IDLE;
      state_reg   <= INIT_STATE;
      toggle_reg  <= 1'b0;
      cnt_reg     <= '0;
      lfsr_reg    <= LFSR_SEED;
      period_reg  <= 16'h0000;
      cfg_err_reg <= 1'b0;
    end else begin
      fsm_reg    <= fsm_next;
      state_reg  <= state_next;
      toggle_reg <= toggle_next;
      cnt_reg    <= cnt_next;
      lfsr_reg   <= lfsr_next;
      period_reg <= period_next;
      if (cfg_fire) cfg_err_reg <= ~(&bound_ok);
    end
  end

  assign cfg_ready_o  = (fsm_reg == IDLE);
  assign busy_o       = (fsm_reg == RUN);
  assign state_o      = state_reg;
  assign toggle_o     = toggle_reg;
  assign cfg_err_o    = cfg_err_reg;
  assign period_cnt_o = period_reg;

endmodule
